maze_game_ctrl: RTL and testbench
=================================

# maze_game_ctrl

Game-flow controller that sequences the maze renderer. It selects the start screen or the maze screen and drives the renderer enable. It owns the character tile position, accepting one directional move per video frame and only onto open path tiles. It detects arrival at the finish tile and returns to the start screen after a timed win hold.

## Interface
Parameters:
- GRID, 16: maze grid pitch; the path bitmap is GRID×GRID, indexed x + GRID*y.
- WIN_FRAMES, 120: number of frames the WIN state holds before returning to IDLE.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame, asserted at vsync start.
- btn_start, btn_up, btn_down, btn_left, btn_right  in  1 each  debounced level inputs.
- path_data  in  GRID*GRID  1 = open tile.
- maze_width, maze_height  in  5 each  maze size in tiles.
- start_x, start_y, finish_x, finish_y  in  5 each  start and finish tile coordinates.
- start_screen  out  1  start screen select.
- maze_screen  out  1  maze screen select.
- enable  out  1  renderer enable.
- char_x, char_y  out  7 each  character tile position; bits [6:5] are always 0.
- move_count  out  16  accepted moves this game; saturates at 16'hFFFF.
- win  out  1  one-cycle pulse on reaching the finish tile.

## Operation
- States: IDLE, LOAD, PLAY, WIN.
- IDLE: start_screen=1, maze_screen=0, enable=0.
  - A btn_start rising edge moves to LOAD only if the config is valid: 1 ≤ maze_width ≤ GRID, 1 ≤ maze_height ≤ GRID, start inside the maze, finish inside the maze.
  - An invalid config ignores the edge.
- LOAD: char ← (start_x, start_y); move_count ← 0; pending moves cleared; go to PLAY.
- PLAY: start_screen=0, maze_screen=1, enable=1.
  - Direction rising edges set sticky pending bits.
  - On frame_tick, at most one move is applied. Priority: up > down > left > right.
  - All pending bits clear on that frame_tick, whether or not the move was accepted.
- Move acceptance: the target tile must lie within [0, maze_width-1] × [0, maze_height-1], with no wrap-around and no negative coordinates. It must also satisfy path_data[tx + GRID*ty] = 1, or equal the start or finish tile.
  - Accepted: char updates and move_count increments.
  - Rejected: no change.
- Win: when the accepted target equals (finish_x, finish_y), win pulses and the state goes to WIN.
- WIN: screen select stays on the maze and enable=1; the frame counter counts frame_tick pulses.
  - After WIN_FRAMES ticks, go to IDLE.
  - btn_start is ignored in WIN.
- btn_start in PLAY restarts: go to LOAD.
- Edges are detected against the previous-cycle level. A button already held on entry to PLAY does not generate an edge.

## Timing
- Reset values: state IDLE, start_screen=1, maze_screen=0, enable=0, char_x=char_y=0, move_count=0, win=0, pending=0, frame counter 0. Reset wins over every other event.
- Button rises at cycle n → edge at n+1 → pending bit set at n+2.
- frame_tick at cycle m → char_x/char_y/move_count/win valid at m+1.
- An edge in the same cycle as frame_tick is applied at the next frame_tick.
- btn_start edge at cycle n → LOAD at n+1 → PLAY at n+2, with char already equal to start.
- WIN entered at cycle m+1 → IDLE on the cycle after the WIN_FRAMES-th subsequent frame_tick.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `maze_pkg`: state encoding, GRID, tile coordinate width (5), position output width (7).
- Sub-module `btn_edge`: registered rising-edge detector, 5 instances (start plus four directions).
- FSM, move-legality logic and counters live in the top module.

## Test plan
- Reset, then GRID=16, maze 8×8, start (0,0), finish (2,0), path row 0 open. btn_start edge → PLAY in 2 cycles with char=(0,0). Right, then tick, twice → char=(2,0), move_count=2, win pulses once.
- In PLAY at (0,0), press left and up, then tick → rejected for out of bounds; char=(0,0), move_count=0. Next tick with no press → no move.
- Target tile has path bit 0: right + tick → char unchanged. Up and right pending together → up attempted only and right discarded.
- Three right edges within one frame → exactly one move on the tick.
- maze_width=0, btn_start → stays IDLE, start_screen=1. maze_width=17 → stays IDLE.
- In WIN with WIN_FRAMES=3: state is IDLE after 3 ticks. Assert reset mid-PLAY → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared constants, state encoding and helpers for the maze game controller
// Contents:
//   GRID_DEF / COORD_W / POS_W : default grid pitch, tile coordinate width, position output width
//   ST_*                       : game-flow state encoding
//   dir_t                      : one bit per direction (pending moves, button edges)
//   cfg_valid()                : maze size / start / finish sanity check
package maze_pkg;

    localparam int GRID_DEF = 16;
    localparam int COORD_W  = 5;
    localparam int POS_W    = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_WIN  = 2'd3;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    // A maze is playable when both dimensions are 1..grid and both the
    // start and finish tiles fall inside it. sx < w already implies w != 0,
    // but the explicit checks keep the intent readable.
    function automatic logic cfg_valid(
        input logic [COORD_W-1:0] w,
        input logic [COORD_W-1:0] h,
        input logic [COORD_W-1:0] sx,
        input logic [COORD_W-1:0] sy,
        input logic [COORD_W-1:0] fx,
        input logic [COORD_W-1:0] fy,
        input logic [COORD_W-1:0] grid
    );
        return (w != '0) && (w <= grid) &&
               (h != '0) && (h <= grid) &&
               (sx < w) && (sy < h) &&
               (fx < w) && (fy < h);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registered rising-edge detector for a debounced level input
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   btn        : debounced level input
//   rise       : one-cycle pulse, the cycle after btn is first seen high
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        prev_d = btn;
        rise_d = btn & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/maze_game_ctrl.sv
// rtl/maze_game_ctrl.sv - game-flow FSM, character movement and win hold for the maze renderer
// Ports:
//   clk, reset                       : system clock, synchronous active-high reset
//   frame_tick                       : one pulse per video frame
//   btn_start/up/down/left/right     : debounced buttons
//   path_data                        : GRIDxGRID open-tile bitmap, index x + GRID*y
//   maze_width/height, start_*, finish_* : maze configuration in tiles
//   start_screen/maze_screen/enable  : renderer control
//   char_x/char_y                    : character tile position
//   move_count                       : accepted moves this game, saturating
//   win                              : one-cycle pulse on reaching the finish tile
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int GRID       = GRID_DEF,
    parameter int WIN_FRAMES = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 btn_start,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic [GRID*GRID-1:0] path_data,
    input  logic [COORD_W-1:0]   maze_width,
    input  logic [COORD_W-1:0]   maze_height,
    input  logic [COORD_W-1:0]   start_x,
    input  logic [COORD_W-1:0]   start_y,
    input  logic [COORD_W-1:0]   finish_x,
    input  logic [COORD_W-1:0]   finish_y,
    output logic                 start_screen,
    output logic                 maze_screen,
    output logic                 enable,
    output logic [POS_W-1:0]     char_x,
    output logic [POS_W-1:0]     char_y,
    output logic [15:0]          move_count,
    output logic                 win
);

    localparam int IDX_W = $clog2(GRID*GRID);
    localparam int CNT_W = $clog2(WIN_FRAMES + 1);
    localparam logic [COORD_W-1:0] GRID_C   = COORD_W'(GRID);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIN_FRAMES - 1);

    // ------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------
    logic start_rise;
    dir_t dir_rise;

    btn_edge u_edge_start (.clk(clk), .reset(reset), .btn(btn_start), .rise(start_rise));
    btn_edge u_edge_up    (.clk(clk), .reset(reset), .btn(btn_up),    .rise(dir_rise.up));
    btn_edge u_edge_down  (.clk(clk), .reset(reset), .btn(btn_down),  .rise(dir_rise.down));
    btn_edge u_edge_left  (.clk(clk), .reset(reset), .btn(btn_left),  .rise(dir_rise.left));
    btn_edge u_edge_right (.clk(clk), .reset(reset), .btn(btn_right), .rise(dir_rise.right));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [15:0]        cnt_q, cnt_d;
    dir_t               pend_q, pend_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic               win_q, win_d;
    logic               start_screen_q, start_screen_d;
    logic               maze_screen_q, maze_screen_d;
    logic               enable_q, enable_d;

    // ------------------------------------------------------------------
    // Move legality: the single highest-priority pending direction is
    // the only one attempted; the rest are dropped on the same tick.
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] tgt_x, tgt_y;
    logic               try_move;
    logic               in_bounds;
    logic [IDX_W-1:0]   tgt_idx;
    logic               tgt_open;
    logic               tgt_special;
    logic               tgt_finish;
    logic               accept;

    always_comb begin
        tgt_x     = x_q;
        tgt_y     = y_q;
        try_move  = 1'b1;
        in_bounds = 1'b0;
        if (pend_q.up) begin
            tgt_y     = y_q - 1'b1;
            in_bounds = (y_q != '0) && (tgt_y < maze_height) && (x_q < maze_width);
        end else if (pend_q.down) begin
            tgt_y     = y_q + 1'b1;
            in_bounds = (y_q != '1) && (tgt_y < maze_height) && (x_q < maze_width);
        end else if (pend_q.left) begin
            tgt_x     = x_q - 1'b1;
            in_bounds = (x_q != '0) && (tgt_x < maze_width) && (y_q < maze_height);
        end else if (pend_q.right) begin
            tgt_x     = x_q + 1'b1;
            in_bounds = (x_q != '1) && (tgt_x < maze_width) && (y_q < maze_height);
        end else begin
            try_move  = 1'b0;
        end

        // Index is only meaningful when in_bounds holds; accept gates it.
        tgt_idx     = IDX_W'(tgt_x) + IDX_W'(GRID) * IDX_W'(tgt_y);
        tgt_open    = path_data[tgt_idx];
        tgt_finish  = (tgt_x == finish_x) && (tgt_y == finish_y);
        tgt_special = tgt_finish || ((tgt_x == start_x) && (tgt_y == start_y));
        accept      = try_move && in_bounds && (tgt_open || tgt_special);
    end

    // ------------------------------------------------------------------
    // Game-flow FSM and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        pend_d  = '0;
        fcnt_d  = fcnt_q;
        win_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise && cfg_valid(maze_width, maze_height, start_x, start_y,
                                            finish_x, finish_y, GRID_C)) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                x_d     = start_x;
                y_d     = start_y;
                cnt_d   = '0;
                state_d = ST_PLAY;
            end

            ST_PLAY: begin
                if (start_rise) begin
                    state_d = ST_LOAD;
                end else begin
                    // An edge landing on the tick cycle survives into the next frame.
                    pend_d = (frame_tick ? dir_t'('0) : pend_q) | dir_rise;
                    if (frame_tick && accept) begin
                        x_d = tgt_x;
                        y_d = tgt_y;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        if (tgt_finish) begin
                            win_d   = 1'b1;
                            fcnt_d  = '0;
                            state_d = ST_WIN;
                        end
                    end
                end
            end

            default: begin // ST_WIN
                if (frame_tick) begin
                    if (fcnt_q == LAST_CNT) begin
                        fcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        fcnt_d  = fcnt_q + 1'b1;
                    end
                end
            end
        endcase

        // Screen controls are registered from the next state so they line
        // up with state_q on every cycle.
        start_screen_d = (state_d == ST_IDLE);
        maze_screen_d  = (state_d != ST_IDLE);
        enable_d       = (state_d == ST_PLAY) || (state_d == ST_WIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            x_q            <= '0;
            y_q            <= '0;
            cnt_q          <= '0;
            pend_q         <= '0;
            fcnt_q         <= '0;
            win_q          <= 1'b0;
            start_screen_q <= 1'b1;
            maze_screen_q  <= 1'b0;
            enable_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            fcnt_q         <= fcnt_d;
            win_q          <= win_d;
            start_screen_q <= start_screen_d;
            maze_screen_q  <= maze_screen_d;
            enable_q       <= enable_d;
        end
    end

    assign start_screen = start_screen_q;
    assign maze_screen  = maze_screen_q;
    assign enable       = enable_q;
    assign char_x       = {{(POS_W-COORD_W){1'b0}}, x_q};
    assign char_y       = {{(POS_W-COORD_W){1'b0}}, y_q};
    assign move_count   = cnt_q;
    assign win          = win_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb/tb_maze_game_ctrl.sv - scoreboard bench for maze_game_ctrl
module tb_maze_game_ctrl;

    localparam int GRID = 16;
    localparam int WF   = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             frame_tick = 1'b0;
    logic             btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic             btn_left = 1'b0, btn_right = 1'b0;
    logic [GRID*GRID-1:0] path_data = '0;
    logic [4:0]       maze_width = 5'd8, maze_height = 5'd8;
    logic [4:0]       start_x = 5'd0, start_y = 5'd0, finish_x = 5'd2, finish_y = 5'd0;
    logic             start_screen, maze_screen, enable, win;
    logic [6:0]       char_x, char_y;
    logic [15:0]      move_count;

    maze_game_ctrl #(.GRID(GRID), .WIN_FRAMES(WF)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .path_data(path_data), .maze_width(maze_width), .maze_height(maze_height),
        .start_x(start_x), .start_y(start_y), .finish_x(finish_x), .finish_y(finish_y),
        .start_screen(start_screen), .maze_screen(maze_screen), .enable(enable),
        .char_x(char_x), .char_y(char_y), .move_count(move_count), .win(win)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int cnt;
        int w;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model of the character
    int m_x = 0, m_y = 0, m_cnt = 0;
    bit p_up = 0, p_down = 0, p_left = 0, p_right = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(int tx, int ty);
        if (tx < 0 || ty < 0 || tx >= int'(maze_width) || ty >= int'(maze_height)) return 1'b0;
        if (tx == int'(start_x) && ty == int'(start_y)) return 1'b1;
        if (tx == int'(finish_x) && ty == int'(finish_y)) return 1'b1;
        return path_data[tx + GRID*ty];
    endfunction

    task automatic press(input bit u, input bit d, input bit l, input bit r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        step();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        step();
        step();
        p_up |= u; p_down |= d; p_left |= l; p_right |= r;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".char_x"}, char_x, e.x);
        check({tag, ".char_y"}, char_y, e.y);
        check({tag, ".move_count"}, move_count, e.cnt);
        check({tag, ".win"}, win, e.w);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        int tx, ty;
        bit any;
        tx = m_x; ty = m_y; any = 1;
        if (p_up)         ty = ty - 1;
        else if (p_down)  ty = ty + 1;
        else if (p_left)  tx = tx - 1;
        else if (p_right) tx = tx + 1;
        else              any = 0;
        e.w = 0;
        if (any && legal(tx, ty)) begin
            m_x = tx; m_y = ty;
            if (m_cnt < 65535) m_cnt++;
            if (tx == int'(finish_x) && ty == int'(finish_y)) e.w = 1;
        end
        p_up = 0; p_down = 0; p_left = 0; p_right = 0;
        e.x = m_x; e.y = m_y; e.cnt = m_cnt;
        sb.push_back(e);
        frame_tick = 1;
        step();
        frame_tick = 0;
        pop_compare(tag);
    endtask

    // Start press: edge, LOAD, PLAY. Returns with PLAY outputs visible.
    task automatic raw_start();
        btn_start = 1;
        step();
        btn_start = 0;
        step();
        step();
    endtask

    task automatic start_game(input string tag);
        raw_start();
        m_x = int'(start_x); m_y = int'(start_y); m_cnt = 0;
        p_up = 0; p_down = 0; p_left = 0; p_right = 0;
        check({tag, ".maze_screen"}, maze_screen, 1);
        check({tag, ".enable"}, enable, 1);
        check({tag, ".char_x"}, char_x, m_x);
        check({tag, ".char_y"}, char_y, m_y);
        check({tag, ".move_count"}, move_count, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".start_screen"}, start_screen, 1);
        check({tag, ".maze_screen"}, maze_screen, 0);
        check({tag, ".enable"}, enable, 0);
        check({tag, ".char_x"}, char_x, 0);
        check({tag, ".char_y"}, char_y, 0);
        check({tag, ".move_count"}, move_count, 0);
        check({tag, ".win"}, win, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        path_data[7:0] = 8'hFF;   // row 0 open, everything else closed
        repeat (3) step();
        reset = 0;
        check_reset_vals("reset");

        // Game 1: walk right twice onto the finish
        start_game("start1");
        press(0, 0, 0, 1);
        tick("right1");
        press(0, 0, 0, 1);
        tick("right2_win");
        step();
        check("win_one_pulse", win, 0);
        check("win.maze_screen", maze_screen, 1);
        check("win.enable", enable, 1);

        // Start is ignored while holding the win screen
        raw_start();
        check("win_start_ignored", maze_screen, 1);
        tick("win_t1");
        check("win_t1.maze_screen", maze_screen, 1);
        tick("win_t2");
        check("win_t2.maze_screen", maze_screen, 1);
        tick("win_t3");
        check("win_t3.start_screen", start_screen, 1);
        check("win_t3.enable", enable, 0);

        // Game 2: rejected moves and priority
        start_game("start2");
        press(1, 0, 1, 0);
        tick("oob_up_left");
        tick("no_press");
        press(0, 1, 0, 0);
        tick("closed_down");
        press(1, 0, 0, 1);
        tick("up_over_right");
        tick("right_discarded");
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        tick("three_rights");

        // Restart from PLAY
        start_game("restart");

        // Edge landing on the tick cycle is deferred to the next frame
        begin
            exp_t e;
            btn_right = 1;
            step();
            btn_right = 0;
            frame_tick = 1;
            e.x = m_x; e.y = m_y; e.cnt = m_cnt; e.w = 0;
            sb.push_back(e);
            step();
            frame_tick = 0;
            pop_compare("edge_on_tick");
            p_right = 1;
        end
        tick("deferred_right");

        // Reset in the middle of play
        reset = 1;
        step();
        reset = 0;
        check_reset_vals("mid_reset");

        // Invalid configurations leave the controller idle
        maze_width = 5'd0;
        raw_start();
        check("w0.start_screen", start_screen, 1);
        check("w0.maze_screen", maze_screen, 0);
        maze_width = 5'd17;
        raw_start();
        check("w17.start_screen", start_screen, 1);
        maze_width = 5'd8;
        finish_x = 5'd8;
        raw_start();
        check("finish_out.start_screen", start_screen, 1);
        finish_x = 5'd2;
        maze_width = 5'd16;
        start_game("w16_valid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
